// File: rtl/ebd_seq.sv
// ebd_seq: sequential restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module ebd_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dvd,
    input  logic [N-1:0]   dvs,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           ovf,
    output logic           dz
);
    localparam int CW = $clog2(2*N+1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] sr;
    logic [N-1:0]   dv;
    logic [N-1:0]   pr;
    logic [N:0]     pr_sh;
    logic [N-1:0]   pr_nx;
    logic           ge;
    logic [2*N-1:0] sr_nx;
    assign in_ready = state == IDLE;
    // sr shifts dividend bits out the top and quotient bits in the bottom
    assign pr_sh = {pr, sr[2*N-1]};
    assign ge    = pr_sh >= {1'b0, dv};
    assign pr_nx = ge ? N'(pr_sh - {1'b0, dv}) : pr_sh[N-1:0];
    assign sr_nx = {sr[2*N-2:0], ge};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            dv        <= '0;
            pr        <= '0;
            q         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                sr <= dvd;
                dv <= dvs;
                pr <= '0;
                if (dvs == '0) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    q         <= '1;
                    r         <= dvd[N-1:0];
                    ovf       <= 1'b1;
                    dz        <= 1'b1;
                end else begin
                    state <= RUN;
                    cnt   <= CW'(2*N);
                end
            end
        end else if (state == RUN) begin
            sr  <= sr_nx;
            pr  <= pr_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state     <= DONE;
                out_valid <= 1'b1;
                q         <= sr_nx;
                r         <= pr_nx;
                ovf       <= |sr_nx[2*N-1:N];
                dz        <= 1'b0;
            end
        end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ebd_seq.sv
// tb_ebd_seq: scoreboard bench for ebd_seq against arithmetic division and an a*b round trip
module tb_ebd_seq;
    logic        clk = 0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, ovf, dz;
    logic [15:0] dvd, q;
    logic [7:0]  dvs, r;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    logic prev_ov = 0;

    ebd_seq #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dvd(dvd), .dvs(dvs), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // monitor: reads pre-edge values, checks latency on rise and result on handshake
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) prev_ov = 0;
        else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("spurious_valid", 1, 0);
                else chk("latency", cyc, sb[0].acc + sb[0].lat);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {q, r, 6'b0, ovf, dz}, {e.q, e.r, 6'b0, e.ovf, e.dz});
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [15:0] d, input logic [7:0] v);
        int   n = 0;
        exp_t e;
        in_valid = 1; dvd = d; dvs = v;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("accept_timeout", 0, 1); return; end
        e.dz  = (v == 0);
        e.q   = e.dz ? 16'hFFFF : d / {8'b0, v};
        e.r   = e.dz ? d[7:0] : 8'(d % {8'b0, v});
        e.ovf = e.dz || (e.q > 16'd255);
        e.acc = cyc + 1;
        e.lat = e.dz ? 1 : 17;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin chk("drain_timeout", sb.size(), 0); sb.delete(); end
    endtask

    logic [15:0] dl[5] = '{16'd50000, 16'd1000, 16'd0, 16'd65535, 16'h04D2};
    logic [7:0]  vl[5] = '{8'd200, 8'd7, 8'd5, 8'd1, 8'd0};

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; dvd = 0; dvs = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_flags", {ovf, dz}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(dl[i], vl[i]);
            in_valid = 0;
            drain();
        end
        out_ready = 0;
        send(16'd1000, 8'd7);
        in_valid = 0;
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        chk("bp_wait_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid; dvd = 16'($urandom); dvs = 8'($urandom);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_q", q, 142);
            chk("bp_r", r, 6);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        drain();
        send(16'd65025, 8'd255);
        in_valid = 0;
        repeat (6) @(negedge clk);
        in_valid = 1; rst_n = 0;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_r", r, 0);
        chk("midrst_flags", {out_valid, ovf, dz}, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        in_valid = 0; rst_n = 1;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_valid", out_valid, 0);
        send(16'd65025, 8'd255);
        in_valid = 0;
        drain();
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            if (i % 10 == 9) send(16'($urandom), 8'($urandom_range(0, 255)));
            else send(16'(a * b), b);
        end
        in_valid = 0;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
